serial_addsub: RTL and testbench

Parametrised, digit-serial adder/subtractor with valid/ready handshakes on input and output. It is the sequential successor to the team's fixed-width combinational ripple adder. Each operation takes two WIDTH-bit operands and processes DIGIT bits per clock, least-significant digit first, carrying between digits in a register. It returns the sum or difference, the carry out and the signed overflow. It sits in the datapath wherever area matters more than single-cycle latency.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/digit_adder.sv | 31 +++
 rtl/serial_addsub.sv | 103 ++++++++++
 tb/tb_serial_addsub.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state
// encoding and helpers deriving the digit count and counter width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width; at least one bit even when there is a single digit.
  function automatic int calc_cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice. Besides the sum and carry out
// it exposes the carry into its top bit so the caller can form the signed
// overflow flag when this slice holds the operand MSB.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] c;

  // Ripple the carry through the slice bit by bit.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co   = c[DIGIT];
  assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Operands are captured on the input
// handshake, then processed DIGIT bits per cycle, LSB digit first, with the
// inter-digit carry held in a register. Subtraction is A + ~B + 1.
// WIDTH must be a multiple of DIGIT.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = calc_ndig(WIDTH, DIGIT);
  localparam int CW   = calc_cnt_width(WIDTH, DIGIT);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] s_dig;
  logic             co_dig;
  logic             cmsb_dig;
  logic             last_dig;

  assign a_dig    = op_a[cnt*DIGIT +: DIGIT];
  assign b_dig    = op_b[cnt*DIGIT +: DIGIT];
  assign last_dig = (cnt == CW'(NDIG - 1));

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a   (a_dig),
    .b   (b_dig),
    .ci  (carry),
    .s   (s_dig),
    .co  (co_dig),
    .cmsb(cmsb_dig)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // FSM plus operand, result, carry and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          y[cnt*DIGIT +: DIGIT] <= s_dig;
          carry                 <= co_dig;
          if (last_dig) begin
            cout  <= co_dig;
            ovf   <= cmsb_dig ^ co_dig;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub: a WIDTH=16/DIGIT=4
// instance for most scenarios and a WIDTH=16/DIGIT=16 instance for the
// single-digit configuration.
module tb_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        cout;
  logic        ovf;

  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [15:0] y1;
  logic        cout1;
  logic        ovf1;

  int checks;
  int errors;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .cout(cout), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(1'b0), .sub(1'b0), .out_valid(out_valid1),
    .out_ready(out_ready1), .y(y1), .cout(cout1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count negedges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      in_valid = 1'b0;
      if (out_valid || lat >= 30) break;
    end
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, output int lat);
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    wait_done(lat);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string name, input int lat, input int exp_lat,
                              input logic [15:0] ey, input logic ec, input logic eo);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (y !== ey) begin
      errors++; $display("FAIL %s_y got %h want %h", name, y, ey);
    end
    checks++;
    if (cout !== ec) begin
      errors++; $display("FAIL %s_cout got %b want %b", name, cout, ec);
    end
    checks++;
    if (ovf !== eo) begin
      errors++; $display("FAIL %s_ovf got %b want %b", name, ovf, eo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready, in_ready1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (y !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got y=%h c=%b o=%b want 0000/0/0", y, cout, ovf);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat);
    check_result("add", lat, 5, 16'h2233, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_add_boundary();
    int lat;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check_result("add_wrap", lat, 5, 16'h0000, 1'b1, 1'b0);
    release_result();
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, lat);
    check_result("add_ovf", lat, 5, 16'h8000, 1'b0, 1'b1);
    release_result();
  endtask

  task automatic test_sub();
    int lat;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
    check_result("sub_borrow", lat, 5, 16'hFFFE, 1'b0, 1'b0);
    release_result();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    check_result("sub_ovf", lat, 5, 16'h7FFF, 1'b1, 1'b1);
    release_result();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    check_result("sub_cin_ignored", lat, 5, 16'hFFFE, 1'b0, 1'b0);
    release_result();
    run_op(16'h1234, 16'h1234, 1'b1, 1'b1, lat);
    check_result("sub_equal", lat, 5, 16'h0000, 1'b1, 1'b0);
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    check_result("bp_first", lat, 5, 16'h3333, 1'b0, 1'b0);
    a = 16'h0100; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (y !== 16'h3333 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got y=%h c=%b o=%b v=%b want 3333/0/0/1",
                 i, y, cout, ovf, out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready);
      end
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got rdy=%b v=%b want 1/0", in_ready, out_valid);
    end
    wait_done(lat);
    check_result("bp_pending", lat, 5, 16'h0101, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_abort();
    int lat;
    logic seen;
    @(negedge clk);
    a = 16'h4444; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 16'h0000) begin
      errors++;
      $display("FAIL abort_reset got rdy=%b v=%b y=%h want 1/0/0000", in_ready, out_valid, y);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_valid got %b want 0", seen);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat);
    check_result("abort_next", lat, 5, 16'h0100, 1'b0, 1'b0);
    release_result();
  endtask

  task automatic test_single_digit();
    int lat;
    @(negedge clk);
    a1 = 16'h00FF; b1 = 16'h0001; in_valid1 = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      in_valid1 = 1'b0;
      if (out_valid1 || lat >= 30) break;
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL single_latency got %0d want 2", lat);
    end
    checks++;
    if (y1 !== 16'h0100 || cout1 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL single_result got y=%h c=%b o=%b want 0100/0/0", y1, cout1, ovf1);
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL single_release got %b want 1", in_ready1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
    test_reset();
    test_add();
    test_add_boundary();
    test_sub();
    test_backpressure();
    test_abort();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
